hazard_detect_unit: RTL and testbench
=====================================

Name: hazard_detect_unit

Overview:
- Responder to the decode stage's hazard interface.
- Consumes the decode stage's source operands (src1, src2, Two_src) and its destination fields.
- Keeps a two-entry shadow pipeline of in-flight destinations, mirroring the EXE and MEM stages, and returns the single-bit `hazard` stall to decode.
- Register file writes on the falling clock edge, so the WB stage needs no tracking.

Parameters:
- REG_W, 4, register index width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- src1  in  REG_W  decode first source register
- src2  in  REG_W  decode second source register
- Two_src  in  1  decode instruction reads src2
- id_dest  in  REG_W  decode instruction destination (Dest)
- id_wb_en  in  1  decode instruction writes back (WB_EN)
- id_mem_r_en  in  1  decode instruction is a load (MEM_R_EN)
- flush  in  1  branch taken; squash the instruction in decode
- freeze  in  1  memory wait; hold the whole pipeline
- hazard  out  1  stall decode/fetch, insert bubble
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset and clocking:
  - One clock `clk`; reset `rst` is synchronous and active-high.
  - On reset: both shadow entries invalid (valid=0, dest=0, wb_en=0, mem_r_en=0); stall_cnt=0.
  - `hazard` is combinational and is 0 while the entries are invalid.
- Shadow entry: {valid, dest, wb_en, mem_r_en}. Entries are E (mirrors EXE) and M (mirrors MEM).
- Match function: match(s, X) = X.valid & X.wb_en & (X.dest == s).
- Default hazard = match(src1,E) | match(src1,M) | (Two_src & (match(src2,E) | match(src2,M))).
  - src1 is always compared.
  - src2 is compared only when Two_src=1.
- Each rising edge, rst=0, freeze=0:
  - M <= E.
  - If flush or hazard: E <= bubble (valid=0, other fields 0).
  - Otherwise: E <= {1, id_dest, id_wb_en, id_mem_r_en}.
- Freeze:
  - With freeze=1, E, M and stall_cnt hold.
  - `hazard` is still evaluated combinationally from the held entries.
- flush and hazard in the same cycle: bubble inserted once; flush does not mask the `hazard` output.
- stall_cnt:
  - Increments by 1 on each edge with hazard=1 and freeze=0.
  - Saturates at all-ones; no wrap.
- Latency:
  - A producer issued at edge t is visible in E at t+1 and in M at t+2.
  - At t+3 it has left M and no longer causes a hazard.
  - Back-to-back dependent instruction without forwarding: 2 stall cycles.
  - With one independent instruction in between: 1 stall cycle.
- Reset mid-stall: all entries cleared, hazard drops in the same cycle the reset is sampled, counter cleared.
- R0 is not special; a match on index 0 stalls like any other register.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: a forwarding unit exists in EXE.
  - hazard = E.mem_r_en & (match(src1,E) | (Two_src & match(src2,E))), i.e. load-use only.
  - M is never compared.
  - Load followed by dependent instruction: 1 stall cycle.
  - ALU producer followed by dependent instruction: 0 stall cycles.
- Not defined: default full-stall behaviour above.
- Shadow pipeline, freeze, flush and counter rules are identical in both builds.

Decomposition:
- Shared package (hazard_pkg):
  - REG_W
  - shadow entry struct typedef
  - BUBBLE constant (all-zero entry)
- One natural sub-module: hazard_shadow_stage, a single entry register with load, bubble, freeze and synchronous reset; instantiated twice (E and M).
- Match logic and counter stay in the top module.

Test Plan:
- Reset, then idle with all entries invalid -> hazard=0, stall_cnt=0.
- Issue ADD id_dest=3, id_wb_en=1, then decode src1=3, Two_src=0 -> hazard=1 for 2 cycles, 0 on the third; stall_cnt=2. (FORWARDING_EN: hazard=0 throughout.)
- Producer dest=5, then src2=5 with Two_src=0 -> hazard=0. Same with Two_src=1 -> hazard=1.
- LDR id_dest=2, id_mem_r_en=1, then src1=2 -> FORWARDING_EN: hazard=1 for exactly 1 cycle; default build: 2 cycles.
- freeze=1 for 3 cycles while E matches src1 -> hazard stays 1, stall_cnt holds; after release, stall resolves as normal. flush=1 with a producer in decode -> E bubble; the next consumer sees no E match.
- Force stall_cnt to 16'hFFFE, hold hazard for 3 cycles -> stall_cnt=16'hFFFF, no wrap. Assert rst mid-stall -> hazard=0 and stall_cnt=0 after the edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types for the decode-stage hazard detector.
//   REG_W          : register index width
//   shadow_entry_t : one in-flight destination {valid, dest, wb_en, mem_r_en}
//   BUBBLE         : all-zero (invalid) shadow entry
//   match()        : does source register s read what entry x will write?
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_W = 4;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_r_en;
  } shadow_entry_t;

  localparam shadow_entry_t BUBBLE = '0;

  // R0 is deliberately not special-cased: index 0 matches like any register.
  function automatic logic match(input logic [REG_W-1:0] s, input shadow_entry_t x);
    return x.valid & x.wb_en & (x.dest == s);
  endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// ---------------------------------------------------------------------------
// hazard_shadow_stage
// One shadow entry mirroring a pipeline stage register (EXE or MEM).
// Ports:
//   clk       in  clock
//   rst       in  synchronous active-high reset, clears the entry to BUBBLE
//   i_freeze  in  hold the entry (memory wait)
//   i_bubble  in  load BUBBLE instead of i_entry
//   i_entry   in  entry to load on the next edge
//   o_entry   out current entry
// ---------------------------------------------------------------------------
module hazard_shadow_stage
  import hazard_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_freeze,
  input  logic          i_bubble,
  input  shadow_entry_t i_entry,
  output shadow_entry_t o_entry
);

  shadow_entry_t r_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry <= BUBBLE;
    end else if (!i_freeze) begin
      r_entry <= i_bubble ? BUBBLE : i_entry;
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/hazard_detect_unit.sv
// ---------------------------------------------------------------------------
// hazard_detect_unit
// Decode-stage hazard detector. Tracks the destinations in flight in EXE (E)
// and MEM (M) and stalls decode when a source operand depends on one of them.
// WB needs no tracking: the register file writes on the falling edge.
//
// Build option: define FORWARDING_EN when EXE has a forwarding unit. Only a
// load in E then stalls (load-use); M is never compared. Without the macro
// every E/M producer stalls its consumer.
//
// Ports:
//   clk          in  clock
//   rst          in  synchronous active-high reset
//   src1         in  decode first source register (always compared)
//   src2         in  decode second source register (compared when Two_src)
//   Two_src      in  decode instruction reads src2
//   id_dest      in  decode destination register
//   id_wb_en     in  decode instruction writes back
//   id_mem_r_en  in  decode instruction is a load
//   flush        in  branch taken: squash the instruction in decode
//   freeze       in  memory wait: hold entries and counter
//   hazard       out stall decode/fetch and insert a bubble (combinational)
//   stall_cnt    out saturating count of stall cycles
// ---------------------------------------------------------------------------
module hazard_detect_unit #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             Two_src,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             flush,
  input  logic             freeze,
  output logic             hazard,
  output logic [CNT_W-1:0] stall_cnt
);

  import hazard_pkg::*;

  shadow_entry_t    w_e;
  shadow_entry_t    w_m;
  shadow_entry_t    w_id_entry;
  logic             w_hazard;
  logic             w_unused_ok;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_id_entry = '{valid: 1'b1, dest: id_dest, wb_en: id_wb_en, mem_r_en: id_mem_r_en};

  // E takes the decode instruction unless it is squashed or stalled; a flush
  // coinciding with a hazard still yields just the one bubble.
  hazard_shadow_stage u_stage_e (
    .clk      (clk),
    .rst      (rst),
    .i_freeze (freeze),
    .i_bubble (flush | w_hazard),
    .i_entry  (w_id_entry),
    .o_entry  (w_e)
  );

  hazard_shadow_stage u_stage_m (
    .clk      (clk),
    .rst      (rst),
    .i_freeze (freeze),
    .i_bubble (1'b0),
    .i_entry  (w_e),
    .o_entry  (w_m)
  );

  always_comb begin
    w_hazard = 1'b0;
`ifdef FORWARDING_EN
    // Forwarding covers ALU results; only a load in EXE has no data yet.
    w_hazard = w_e.mem_r_en & (match(src1, w_e) | (Two_src & match(src2, w_e)));
`else
    w_hazard = match(src1, w_e) | match(src1, w_m) |
               (Two_src & (match(src2, w_e) | match(src2, w_m)));
`endif
  end

  // The M entry's load flag (all of M with forwarding) is mirrored only to
  // keep the shadow pipeline faithful; nothing consumes it.
`ifdef FORWARDING_EN
  assign w_unused_ok = ^w_m;
`else
  assign w_unused_ok = w_m.mem_r_en;
`endif

  // Counter saturates at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!freeze && w_hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign hazard    = w_hazard;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_detect_unit.sv
module tb_hazard_detect_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  src1, src2, id_dest;
  logic        Two_src, id_wb_en, id_mem_r_en, flush, freeze;
  logic        hazard;
  logic [15:0] stall_cnt;

  typedef struct {
    string       nm;
    logic        hz;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  hazard_detect_unit #(.REG_W(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .src1        (src1),
    .src2        (src2),
    .Two_src     (Two_src),
    .id_dest     (id_dest),
    .id_wb_en    (id_wb_en),
    .id_mem_r_en (id_mem_r_en),
    .flush       (flush),
    .freeze      (freeze),
    .hazard      (hazard),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one decode cycle, queue its expected response, advance one edge.
  task automatic cyc(input string nm, input logic [3:0] s1, input logic [3:0] s2,
                     input logic two, input logic [3:0] d, input logic wb,
                     input logic mr, input logic fl, input logic fr,
                     input logic ehz, input logic [15:0] ecnt);
    exp_t e;
    src1 = s1; src2 = s2; Two_src = two; id_dest = d;
    id_wb_en = wb; id_mem_r_en = mr; flush = fl; freeze = fr;
    e.nm = nm; e.hz = ehz; e.cnt = ecnt;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: compares whatever the driver expected for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (hazard !== e.hz) begin
          errors++;
          $display("FAIL %s hazard actual=%b required=%b", e.nm, hazard, e.hz);
        end
        checks++;
        if (stall_cnt !== e.cnt) begin
          errors++;
          $display("FAIL %s stall_cnt actual=%h required=%h", e.nm, stall_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    src1 = 0; src2 = 0; Two_src = 0; id_dest = 0;
    id_wb_en = 0; id_mem_r_en = 0; flush = 0; freeze = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //   name          s1 s2 two d  wb mr fl fr  hz cnt
    cyc("reset_idle",   0, 0, 0, 0, 0, 0, 0, 0,  0, 16'd0);
    cyc("idle2",        0, 0, 0, 0, 0, 0, 0, 0,  0, 16'd0);

    // ADD r3 then dependent: two stall cycles
    cyc("add_issue",    0, 0, 0, 3, 1, 0, 0, 0,  0, 16'd0);
    cyc("raw_e",        3, 0, 0, 4, 1, 0, 0, 0,  1, 16'd0);
    cyc("raw_m",        3, 0, 0, 4, 1, 0, 0, 0,  1, 16'd1);
    cyc("raw_clear",    3, 0, 0, 4, 1, 0, 0, 0,  0, 16'd2);
    cyc("drain1",       0, 0, 0, 0, 0, 0, 0, 0,  0, 16'd2);
    cyc("drain2",       0, 0, 0, 0, 0, 0, 0, 0,  0, 16'd2);

    // src2 compared only with Two_src
    cyc("p5_issue",     0, 0, 0, 5, 1, 0, 0, 0,  0, 16'd2);
    cyc("src2_no_two",  0, 5, 0, 0, 0, 0, 0, 0,  0, 16'd2);
    cyc("src2_two_m",   0, 5, 1, 0, 0, 0, 0, 0,  1, 16'd2);
    cyc("src2_clear",   0, 5, 1, 0, 0, 0, 0, 0,  0, 16'd3);
    cyc("drain3",       0, 0, 0, 0, 0, 0, 0, 0,  0, 16'd3);

    // LDR r2 then dependent: two cycles in the full-stall build
    cyc("ldr_issue",    0, 0, 0, 2, 1, 1, 0, 0,  0, 16'd3);
    cyc("ldr_use_e",    2, 0, 0, 0, 0, 0, 0, 0,  1, 16'd3);
    cyc("ldr_use_m",    2, 0, 0, 0, 0, 0, 0, 0,  1, 16'd4);
    cyc("ldr_clear",    2, 0, 0, 0, 0, 0, 0, 0,  0, 16'd5);

    // freeze holds entries and counter
    cyc("p6_issue",     0, 0, 0, 6, 1, 0, 0, 0,  0, 16'd5);
    cyc("frz1",         6, 0, 0, 0, 0, 0, 0, 1,  1, 16'd5);
    cyc("frz2",         6, 0, 0, 0, 0, 0, 0, 1,  1, 16'd5);
    cyc("frz3",         6, 0, 0, 0, 0, 0, 0, 1,  1, 16'd5);
    cyc("frz_rel_e",    6, 0, 0, 0, 0, 0, 0, 0,  1, 16'd5);
    cyc("frz_rel_m",    6, 0, 0, 0, 0, 0, 0, 0,  1, 16'd6);
    cyc("frz_clear",    6, 0, 0, 0, 0, 0, 0, 0,  0, 16'd7);

    // flush squashes the producer in decode
    cyc("flush_p8",     0, 0, 0, 8, 1, 0, 1, 0,  0, 16'd7);
    cyc("flush_no_e",   8, 0, 0, 0, 0, 0, 0, 0,  0, 16'd7);
    cyc("flush_no_m",   8, 0, 0, 0, 0, 0, 0, 0,  0, 16'd7);

    // flush together with hazard: hazard still visible, one bubble
    cyc("p9_issue",     0, 0, 0, 9, 1, 0, 0, 0,  0, 16'd7);
    cyc("fl_hz_e",      9, 0, 0, 0, 0, 0, 1, 0,  1, 16'd7);
    cyc("fl_hz_m",      9, 0, 0, 0, 0, 0, 0, 0,  1, 16'd8);
    cyc("fl_hz_clear",  9, 0, 0, 0, 0, 0, 0, 0,  0, 16'd9);

    // R0 is an ordinary register
    cyc("r0_issue",     1, 0, 0, 0, 1, 0, 0, 0,  0, 16'd9);
    cyc("r0_e",         0, 0, 0, 1, 0, 0, 0, 0,  1, 16'd9);
    cyc("r0_m",         0, 0, 0, 1, 0, 0, 0, 0,  1, 16'd10);
    cyc("r0_clear",     0, 0, 0, 1, 0, 0, 0, 0,  0, 16'd11);

    // saturation from 16'hFFFE
    force dut.r_stall_cnt = 16'hFFFE;
    #1 release dut.r_stall_cnt;
    cyc("sat_p10",      1, 0, 0, 10, 1, 0, 0, 0, 0, 16'hFFFE);
    cyc("sat_e",        10, 0, 0, 10, 1, 0, 0, 0, 1, 16'hFFFE);
    cyc("sat_m",        10, 0, 0, 10, 1, 0, 0, 0, 1, 16'hFFFF);
    cyc("sat_clear",    10, 0, 0, 10, 1, 0, 0, 0, 0, 16'hFFFF);
    cyc("sat_nowrap",   10, 0, 0, 0, 0, 0, 0, 0,  1, 16'hFFFF);

    // reset mid-stall: hazard and counter cleared after the reset edge
    rst = 1'b1;
    cyc("rst_sampled",  10, 0, 0, 0, 0, 0, 0, 0,  1, 16'hFFFF);
    rst = 1'b0;
    cyc("rst_after",    10, 0, 0, 0, 0, 0, 0, 0,  0, 16'd0);
    cyc("rst_idle",     10, 0, 0, 0, 0, 0, 0, 0,  0, 16'd0);

    @(posedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
